// File: rtl/prng_pkg.sv
// Shared types and constants for the PRNG stream checker.
package prng_pkg;

  typedef enum logic [1:0] {IDLE, CHECK, REPORT} chk_state_t;

  localparam logic LFSR_FIB = 1'b0;
  localparam logic LFSR_GAL = 1'b1;
  localparam int   SBOX_W   = 8;

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box: recovers the raw LFSR byte from a whitened byte.
module aes_inv_sbox
  import prng_pkg::*;
(
  input  logic [SBOX_W-1:0] din,
  output logic [SBOX_W-1:0] dout
);

  localparam logic [7:0] INV_TBL [256] = '{
    8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
    8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
    8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
    8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
    8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
    8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
    8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
    8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
    8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
    8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
    8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
    8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
    8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
    8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
    8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
    8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
  };

  // Pure table lookup.
  always_comb dout = INV_TBL[din];

endmodule

// File: rtl/prng_stream_checker.sv
// Receive-side PRNG stream checker: un-whitens each byte with the inverse S-box,
// regenerates the expected LFSR byte from seed/sel and compares it MSB first.
// Optional macro PRNG_CHK_STICKY_SAT_EN: saturating err_count plus sticky_err output.
module prng_stream_checker
  import prng_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int WORD_BITS = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       seed,
  input  logic             sel,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  output logic             match,
  output logic [CNT_W-1:0] err_count,
  output logic             busy
`ifdef PRNG_CHK_STICKY_SAT_EN
  ,
  output logic             sticky_err
`endif
);

  // The S-box is 8-bit, so a byte is always 8 compared bits.
  if (WORD_BITS != SBOX_W) begin : g_bad_width
    $error("WORD_BITS must be 8");
  end

  localparam int BC_W = $clog2(WORD_BITS);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WORD_BITS - 1);

  chk_state_t        state;
  logic [SBOX_W-1:0] raw;
  logic [SBOX_W-1:0] rx_sr;
  logic [7:0]        lfsr;
  logic [7:0]        lfsr_nxt;
  logic              sel_q;
  logic [BC_W-1:0]   bit_cnt;
  logic              mism;
  logic              mism_nxt;
  logic              exp_bit;
  logic              fib_fb;
  logic [CNT_W-1:0]  err_inc;

  aes_inv_sbox u_inv_sbox (
    .din  (in_data),
    .dout (raw)
  );

  // Expected bit and one-step advance for whichever LFSR was latched at accept.
  always_comb begin
    fib_fb   = lfsr[7] ^ lfsr[4] ^ lfsr[2];
    exp_bit  = fib_fb;
    lfsr_nxt = {lfsr[6:0], fib_fb};
    if (sel_q == LFSR_GAL) begin
      exp_bit  = lfsr[7];
      lfsr_nxt = {lfsr[6], lfsr[5] ^ lfsr[7], lfsr[4] ^ lfsr[7], lfsr[3] ^ lfsr[7],
                  lfsr[2:0], lfsr[7]};
    end
    mism_nxt = mism | (exp_bit ^ rx_sr[SBOX_W-1]);
  end

  // Next error count: wraps by default, saturates when the sticky option is built in.
  always_comb begin
`ifdef PRNG_CHK_STICKY_SAT_EN
    err_inc = (err_count == {CNT_W{1'b1}}) ? err_count : err_count + CNT_W'(1);
`else
    err_inc = err_count + CNT_W'(1);
`endif
  end

  // Control FSM with registered handshake, status and report outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      match     <= 1'b0;
      err_count <= '0;
      busy      <= 1'b0;
      lfsr      <= '0;
      rx_sr     <= '0;
      bit_cnt   <= '0;
      mism      <= 1'b0;
      sel_q     <= LFSR_FIB;
`ifdef PRNG_CHK_STICKY_SAT_EN
      sticky_err <= 1'b0;
`endif
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            rx_sr    <= raw;
            lfsr     <= seed;
            sel_q    <= sel;
            bit_cnt  <= '0;
            mism     <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= CHECK;
          end
        end
        CHECK: begin
          mism    <= mism_nxt;
          rx_sr   <= {rx_sr[SBOX_W-2:0], 1'b0};
          lfsr    <= lfsr_nxt;
          bit_cnt <= bit_cnt + BC_W'(1);
          // Last bit: the report outputs become visible in the REPORT cycle.
          if (bit_cnt == LAST_BIT) begin
            state     <= REPORT;
            out_valid <= 1'b1;
            match     <= ~mism_nxt;
            if (mism_nxt) begin
              err_count <= err_inc;
`ifdef PRNG_CHK_STICKY_SAT_EN
              sticky_err <= 1'b1;
`endif
            end
          end
        end
        REPORT: begin
          in_ready <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/prng_stream_checker.md
Name: prng_stream_checker

Overview:
- Receive end of the PRNG byte stream. Accepts one S-box-whitened random byte per valid/ready handshake.
- Recovers the raw LFSR byte with the AES inverse S-box, then regenerates the expected 8-bit LFSR stream locally from the same seed and LFSR select.
- Compares bit-serially, MSB first, and reports match/mismatch plus a running error count.
- Used on the test board and in loopback to confirm that a generator output really came from a given seed.

Parameters:
- CNT_W, 8, width of the mismatch counter err_count.
- WORD_BITS, 8, bits compared per byte. Fixed at 8 because the S-box is 8-bit; any other value is illegal.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- seed  input  8  LFSR seed, sampled on the accept cycle only.
- sel  input  1  LFSR select, sampled on the accept cycle: 0 = Fibonacci, 1 = Galois.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  checker can accept a byte.
- in_data  input  8  received whitened random byte.
- out_valid  output  1  one-cycle pulse; match and err_count are updated in this cycle.
- match  output  1  last byte matched; held until the next report.
- err_count  output  CNT_W  number of mismatched bytes since reset.
- busy  output  1  high in CHECK and REPORT.

Behaviour:
- Reset (synchronous, active-high): state IDLE, in_ready=1, out_valid=0, match=0, err_count=0, busy=0, LFSR=0, shift register=0, bit counter=0. Reset mid-CHECK aborts the check with no report and no count change.
- FSM states: IDLE -> CHECK -> REPORT -> IDLE.
- IDLE:
  - in_ready=1.
  - Accept on in_valid & in_ready: rx_sr <= inv_sbox(in_data); lfsr <= seed; sel_q <= sel; bit_cnt <= 0; mism <= 0; next state CHECK.
  - With in_valid low, stay in IDLE.
- CHECK (exactly 8 cycles):
  - in_ready=0.
  - Each cycle: exp = LFSR output bit; mism <= mism | (exp ^ rx_sr[7]); rx_sr shifts left by 1; LFSR advances one step; bit_cnt++.
  - When bit_cnt==7 is consumed, go to REPORT.
- REPORT (1 cycle):
  - out_valid=1 and match=~mism. match stays registered until the next REPORT.
  - If mism, err_count increments; at all-ones it wraps to 0.
  - in_ready=0; next state IDLE.
- Latency: accept at edge t; out_valid is high in the cycle after edge t+8. Next accept is possible at edge t+10. Throughput is 1 byte per 10 cycles.
- in_data, seed and sel changing during CHECK or REPORT are ignored.
- Fibonacci LFSR (sel=0):
  - fb = s7^s4^s2; output bit = fb.
  - Step: s <= {s[6:0], fb}.
- Galois LFSR (sel=1):
  - fb = s7; output bit = s7.
  - Step: s7<=s6, s6<=s5^fb, s5<=s4^fb, s4<=s3^fb, s[3:0]<={s[2:0], fb}.
- Bit order: the first LFSR output bit corresponds to bit 7 of the raw byte. This is the same as a left-shifting serial-in capture.
- A seed of 0x00 is legal. The LFSR stays at 0, so the expected raw byte is 0x00 and the expected whitened byte is 0x63.

Optional Feature:
- Macro PRNG_CHK_STICKY_SAT_EN.
- Defined: err_count saturates at all-ones instead of wrapping. Add output port sticky_err, which is set on the first mismatch and cleared only by reset.
- Undefined: err_count wraps and port sticky_err is absent.

Decomposition:
- Package prng_pkg holds:
  - enum chk_state_t {IDLE, CHECK, REPORT};
  - constants LFSR_FIB=1'b0, LFSR_GAL=1'b1, SBOX_W=8.
- Sub-module aes_inv_sbox: combinational 8-bit inverse AES S-box as a 256-entry table. It must satisfy inv_sbox(sbox(x))==x for all x.
- The two LFSRs are inlined as one next-state mux on sel_q.

Test Plan:
1. After reset: in_ready=1, err_count=0, match=0. Then sel=0, seed=0x00, in_data=0x63 -> out_valid pulse 9 cycles after accept, match=1, err_count=0.
2. sel=0, seed=0x01, in_data=0xD8 (raw 0x2D) -> match=1. Same seed with in_data=0xD9 -> match=0, err_count=1.
3. sel=1, seed=0x01, in_data=0x7C (raw 0x01) -> match=1. Then sel=0, seed=0x01, in_data=0x7C -> match=0, err_count=2.
4. Hold in_valid=1 continuously with five matching bytes -> in_ready low for 9 of every 10 cycles, exactly 5 out_valid pulses, no byte lost or double-counted.
5. Reset asserted on the 4th CHECK cycle -> no out_valid, err_count=0, in_ready=1 on the next cycle.
6. Force 2^CNT_W+1 mismatches -> err_count=1 without the macro; with PRNG_CHK_STICKY_SAT_EN, err_count=all-ones and sticky_err=1.
